// File: rtl/ibex_defines.sv
// Shared M-extension types: multdiv operator encoding and the sequencer state set.
package ibex_defines;

  typedef enum logic [1:0] {
    MD_OP_MULL = 2'd0,
    MD_OP_MULH = 2'd1,
    MD_OP_DIV  = 2'd2,
    MD_OP_REM  = 2'd3
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } msq_state_e;

  // One complete operation; doubles as the result-cache key.
  typedef struct packed {
    md_op_e      op;
    logic [1:0]  signed_mode;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
  } md_req_t;

  function automatic logic is_mult(input md_op_e op);
    return (op == MD_OP_MULL) || (op == MD_OP_MULH);
  endfunction

endpackage

// File: rtl/ibex_multdiv_seq.sv
// Sequencer between ID and the multi-cycle multdiv: request/response handshakes,
// flush handling, cycle watchdog, one-entry result cache and stall pulse.
module ibex_multdiv_seq
  import ibex_defines::*;
#(
  parameter bit          RV32M       = 1'b1,
  parameter int unsigned MaxCycles   = 40,
  parameter bit          ResultCache = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  md_op_e      req_op_i,
  input  logic [1:0]  req_signed_mode_i,
  input  logic [31:0] req_operand_a_i,
  input  logic [31:0] req_operand_b_i,
  input  logic        flush_i,
  output logic        md_mult_en_o,
  output logic        md_div_en_o,
  output md_op_e      md_operator_o,
  output logic [1:0]  md_signed_mode_o,
  output logic [31:0] md_operand_a_o,
  output logic [31:0] md_operand_b_o,
  input  logic        md_valid_i,
  input  logic [31:0] md_result_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_result_o,
  output logic        rsp_err_o,
  output logic        busy_o,
  output logic        perf_stall_o
);

  localparam int unsigned     CntW   = $clog2(MaxCycles + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MaxCycles);

  msq_state_e      state, state_next;
  md_req_t         req_now, req_q, cache_key;
  logic            cache_vld;
  logic [31:0]     cache_res, result_q;
  logic            err_q, stall_q;
  logic [CntW-1:0] cnt, cnt_inc;
  logic            accept, hit, done, expire;

  assign req_now = '{op:          req_op_i,
                     signed_mode: req_signed_mode_i,
                     operand_a:   req_operand_a_i,
                     operand_b:   req_operand_b_i};

  assign accept  = (state == IDLE) & req_valid_i & ~flush_i;
  assign hit     = ResultCache & RV32M & cache_vld & (cache_key == req_now);
  assign cnt_inc = (cnt == CntMax) ? cnt : cnt + 1'b1;
  // flush_i outranks both completion and watchdog expiry.
  assign done    = (state == RUN) & md_valid_i & ~flush_i;
  assign expire  = (state == RUN) & ~md_valid_i & ~flush_i & (cnt_inc == CntMax);

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_next = (!RV32M || hit) ? RESP : RUN;
        end
      end
      RUN: begin
        if (flush_i || expire) begin
          state_next = DRAIN;
        end else if (md_valid_i) begin
          state_next = RESP;
        end
      end
      // err_q is only set here by a watchdog expiry; a flushed RUN leaves it clear.
      DRAIN: state_next = (err_q && !flush_i) ? RESP : IDLE;
      RESP: begin
        if (flush_i || rsp_ready_i) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready_o  = 1'b0;
    md_mult_en_o = 1'b0;
    md_div_en_o  = 1'b0;
    rsp_valid_o  = 1'b0;
    unique case (state)
      IDLE: req_ready_o = ~flush_i;
      RUN: begin
        md_mult_en_o = RV32M & is_mult(req_q.op);
        md_div_en_o  = RV32M & ~is_mult(req_q.op);
      end
      RESP:    rsp_valid_o = 1'b1;
      default: ;
    endcase
  end

  assign busy_o           = (state != IDLE);
  assign rsp_result_o     = (state == RESP) ? result_q : 32'h0;
  assign rsp_err_o        = (state == RESP) & err_q;
  assign perf_stall_o     = stall_q;
  assign md_operator_o    = req_q.op;
  assign md_signed_mode_o = req_q.signed_mode;
  assign md_operand_a_o   = req_q.operand_a;
  assign md_operand_b_o   = req_q.operand_b;

  // Operand latch, counter, result and cache
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_q     <= '0;
      cnt       <= '0;
      result_q  <= '0;
      err_q     <= 1'b0;
      stall_q   <= 1'b0;
      cache_vld <= 1'b0;
      cache_key <= '0;
      cache_res <= '0;
    end else begin
      // Registered so the pulse has no combinational path from md_valid_i.
      stall_q <= (state == RUN) & ~md_valid_i;
      if (accept) begin
        req_q <= req_now;
        cnt   <= '0;
        if (!RV32M) begin
          result_q <= '0;
          err_q    <= 1'b1;
        end else if (hit) begin
          result_q <= cache_res;
          err_q    <= 1'b0;
        end else begin
          result_q <= '0;
          err_q    <= 1'b0;
        end
      end else if (state == RUN) begin
        cnt <= cnt_inc;
        if (done) begin
          result_q <= md_result_i;
          if (ResultCache) begin
            cache_vld <= 1'b1;
            cache_key <= req_q;
            cache_res <= md_result_i;
          end
        end else if (expire) begin
          result_q <= '0;
          err_q    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ibex_multdiv_seq.sv
// Scoreboard bench for ibex_multdiv_seq: directed timing scenarios plus random
// operations, with a latency-programmable multdiv stub and an RV32M reference model.
module tb_ibex_multdiv_seq;
  import ibex_defines::*;

  localparam int MAXC = 40;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        req_valid_i, req_ready_o;
  md_op_e      req_op_i;
  logic [1:0]  req_signed_mode_i;
  logic [31:0] req_operand_a_i, req_operand_b_i;
  logic        flush_i;
  logic        md_mult_en_o, md_div_en_o;
  md_op_e      md_operator_o;
  logic [1:0]  md_signed_mode_o;
  logic [31:0] md_operand_a_o, md_operand_b_o;
  logic        md_valid_i;
  logic [31:0] md_result_i;
  logic        rsp_valid_o, rsp_ready_i;
  logic [31:0] rsp_result_o;
  logic        rsp_err_o, busy_o, perf_stall_o;

  always #5 clk = ~clk;

  ibex_multdiv_seq #(.RV32M(1'b1), .MaxCycles(MAXC), .ResultCache(1'b1)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .req_signed_mode_i(req_signed_mode_i), .req_operand_a_i(req_operand_a_i),
    .req_operand_b_i(req_operand_b_i), .flush_i(flush_i),
    .md_mult_en_o(md_mult_en_o), .md_div_en_o(md_div_en_o), .md_operator_o(md_operator_o),
    .md_signed_mode_o(md_signed_mode_o), .md_operand_a_o(md_operand_a_o),
    .md_operand_b_o(md_operand_b_o), .md_valid_i(md_valid_i), .md_result_i(md_result_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_result_o(rsp_result_o),
    .rsp_err_o(rsp_err_o), .busy_o(busy_o), .perf_stall_o(perf_stall_o)
  );

  typedef struct packed {
    logic [31:0] res;
    logic        err;
  } exp_t;

  int   total = 0;
  int   bad = 0;
  exp_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // RV32M semantics from plain arithmetic; signed_mode[0] = a signed, [1] = b signed.
  function automatic logic [31:0] ref_md(input md_op_e op, input logic [1:0] sm,
                                         input logic [31:0] a, input logic [31:0] b);
    logic signed [65:0] pa, pb, prod;
    longint sa, sb;
    pa   = sm[0] ? {{34{a[31]}}, a} : {34'b0, a};
    pb   = sm[1] ? {{34{b[31]}}, b} : {34'b0, b};
    prod = pa * pb;
    if (op == MD_OP_MULL) return prod[31:0];
    if (op == MD_OP_MULH) return prod[63:32];
    if (b == 32'h0) return (op == MD_OP_DIV) ? 32'hFFFF_FFFF : a;
    if (sm == 2'b11) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'b0, a});
      sb = longint'({32'b0, b});
    end
    if (op == MD_OP_DIV) return 32'(sa / sb);
    return 32'(sa % sb);
  endfunction

  // Multdiv stub: md_valid_i in the stub_lat-th consecutive enabled cycle.
  int stub_lat = 1;
  int stub_cnt = 0;
  initial begin
    md_valid_i  = 1'b0;
    md_result_i = 32'h0;
    forever begin
      @(negedge clk);
      if (md_mult_en_o || md_div_en_o) begin
        stub_cnt++;
        md_valid_i  = (stub_cnt == stub_lat);
        md_result_i = md_valid_i ? ref_md(md_operator_o, md_signed_mode_o, md_operand_a_o,
                                          md_operand_b_o) : $urandom;
      end else begin
        stub_cnt    = 0;
        md_valid_i  = 1'b0;
        md_result_i = $urandom;
      end
    end
  end

  // Writeback ready: always-ready or random, with an optional hold-low window in RESP.
  int hold_n  = 0;
  bit rnd_rdy = 1'b0;
  initial begin
    rsp_ready_i = 1'b0;
    forever begin
      @(negedge clk);
      if (rsp_valid_o && hold_n > 0) begin
        rsp_ready_i = 1'b0;
        hold_n--;
      end else begin
        rsp_ready_i = rnd_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
    end
  end

  // Monitor: every response handshake is checked against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst_ni === 1'b1 && rsp_valid_o && rsp_ready_i) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rsp_unexpected: got result %0h err %0b, required no response",
                   rsp_result_o, rsp_err_o);
        end else begin
          e = q.pop_front();
          chk("rsp_result", rsp_result_o, e.res);
          chk("rsp_err", {31'b0, rsp_err_o}, {31'b0, e.err});
        end
      end
    end
  end

  // Model of the one-entry cache
  bit          m_vld = 1'b0;
  md_op_e      m_op;
  logic [1:0]  m_sm;
  logic [31:0] m_a, m_b;

  int o_mul, o_div, o_stall, o_rsp_k, o_end_k, o_rspv;
  bit o_hold_ok, o_flush_ok;

  // Called just after a negedge with the DUT idle. flush_at = RUN cycle (1-based) to flush in.
  task automatic do_op(input md_op_e op, input logic [1:0] sm, input logic [31:0] a,
                       input logic [31:0] b, input int lat, input int flush_at_in);
    int n, lim, exp_en, exp_k, flush_at;
    bit hit;
    logic [31:0] first_res;
    flush_at          = flush_at_in;
    stub_lat          = lat;
    req_op_i          = op;
    req_signed_mode_i = sm;
    req_operand_a_i   = a;
    req_operand_b_i   = b;
    req_valid_i       = 1'b1;
    #1;
    n = 0;
    while (!req_ready_o && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!req_ready_o) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: req_ready_o stayed %0b, required 1", req_ready_o);
      req_valid_i = 1'b0;
      return;
    end
    lim = (lat > MAXC) ? MAXC : lat;
    hit = m_vld && (m_op == op) && (m_sm == sm) && (m_a == a) && (m_b == b);
    if (hit) begin
      flush_at = 0;
      q.push_back('{res: ref_md(op, sm, a, b), err: 1'b0});
      exp_en = 0;
      exp_k  = 0;
    end else if (flush_at > 0) begin
      exp_en = flush_at;
      exp_k  = -1;
    end else if (lat <= MAXC) begin
      q.push_back('{res: ref_md(op, sm, a, b), err: 1'b0});
      m_vld = 1'b1; m_op = op; m_sm = sm; m_a = a; m_b = b;
      exp_en = lat;
      exp_k  = lat;
    end else begin
      q.push_back('{res: 32'h0, err: 1'b1});
      exp_en = lim;
      exp_k  = MAXC + 1;
    end
    o_mul = 0; o_div = 0; o_stall = 0; o_rspv = 0;
    o_rsp_k = -1; o_end_k = -1;
    o_hold_ok = 1'b1; o_flush_ok = 1'b1;
    first_res = 32'h0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (k == 0) req_valid_i = 1'b0;
      flush_i = (flush_at > 0) && (k == flush_at - 1);
      #1;
      if (md_mult_en_o) o_mul++;
      if (md_div_en_o) o_div++;
      if (perf_stall_o) o_stall++;
      if (rsp_valid_o) begin
        if (o_rsp_k < 0) begin
          o_rsp_k   = k;
          first_res = rsp_result_o;
        end
        o_rspv++;
        if (rsp_result_o !== first_res || req_ready_o) o_hold_ok = 1'b0;
      end
      if (flush_at > 0 && k == flush_at && (md_mult_en_o || md_div_en_o || req_ready_o))
        o_flush_ok = 1'b0;
      if (flush_at > 0 && k == flush_at + 1 && !req_ready_o) o_flush_ok = 1'b0;
      if (o_end_k >= 0) break;
      if (!busy_o) o_end_k = k;
    end
    flush_i = 1'b0;
    if (o_end_k < 0) begin
      total++;
      bad++;
      $display("FAIL op_timeout: busy_o still %0b, required 0", busy_o);
    end
    chk("enable_cycles", o_mul + o_div, exp_en);
    if (is_mult(op)) chk("div_en_quiet", o_div, 0);
    else chk("mult_en_quiet", o_mul, 0);
    chk("rsp_latency", o_rsp_k, exp_k);
    if (flush_at > 0) chk("flush_drain", {31'b0, o_flush_ok}, 32'd1);
  endtask

  initial begin
    md_op_e      op;
    logic [1:0]  sm;
    logic [31:0] a, b;
    int          lat, fl, sel;
    rst_ni = 1'b0;
    req_valid_i = 1'b0;
    req_op_i = MD_OP_MULL;
    req_signed_mode_i = 2'b00;
    req_operand_a_i = 32'h0;
    req_operand_b_i = 32'h0;
    flush_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_req_ready", {31'b0, req_ready_o}, 32'd1);
    chk("reset_busy", {31'b0, busy_o}, 32'd0);
    chk("reset_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
    chk("reset_enables", {30'b0, md_mult_en_o, md_div_en_o}, 32'd0);
    chk("reset_operand_a", md_operand_a_o, 32'h0);
    chk("reset_result", rsp_result_o, 32'h0);
    chk("reset_stall", {31'b0, perf_stall_o}, 32'd0);
    flush_i = 1'b1;
    #1;
    chk("reset_ready_flush", {31'b0, req_ready_o}, 32'd0);
    @(negedge clk);
    flush_i = 1'b0;
    rst_ni = 1'b1;
    @(negedge clk);

    // Flush in IDLE blocks a coincident request.
    flush_i = 1'b1;
    req_valid_i = 1'b1;
    req_op_i = MD_OP_MULL;
    #1;
    chk("idle_flush_ready", {31'b0, req_ready_o}, 32'd0);
    @(negedge clk);
    #1;
    chk("idle_flush_busy", {31'b0, busy_o}, 32'd0);
    flush_i = 1'b0;
    req_valid_i = 1'b0;
    @(negedge clk);

    do_op(MD_OP_MULL, 2'b00, 32'd3, 32'd5, 3, 0);
    chk("mull_stall_pulses", o_stall, 2);

    do_op(MD_OP_DIV, 2'b11, 32'd100, 32'd7, 34, 0);
    chk("div_busy_span", o_end_k, 35);

    do_op(MD_OP_DIV, 2'b11, 32'd200, 32'd9, 10, 10);
    chk("flush_no_rsp", o_rspv, 0);

    do_op(MD_OP_MULH, 2'b11, 32'h8000_0000, 32'd2, 6, 0);
    do_op(MD_OP_MULH, 2'b11, 32'h8000_0000, 32'd2, 6, 0);

    do_op(MD_OP_REM, 2'b00, 32'd77, 32'd5, 1000, 0);

    hold_n = 5;
    do_op(MD_OP_MULL, 2'b00, 32'd7, 32'd9, 2, 0);
    chk("hold_stable", {31'b0, o_hold_ok}, 32'd1);
    chk("hold_cycles", o_rspv, 6);
    chk("hold_span", o_end_k, 8);

    rnd_rdy = 1'b1;
    op = MD_OP_MULL; sm = 2'b00; a = 32'h0; b = 32'h0;
    for (int i = 0; i < 150; i++) begin
      if (i == 0 || $urandom_range(0, 3) != 0) begin
        op  = md_op_e'($urandom_range(0, 3));
        sm  = is_mult(op) ? 2'($urandom_range(0, 3)) : ($urandom_range(0, 1) ? 2'b11 : 2'b00);
        sel = $urandom_range(0, 7);
        a   = $urandom;
        b   = $urandom;
        if (sel == 0) b = 32'h0;
        if (sel == 1) b = 32'($urandom_range(1, 15));
        if (sel == 2) begin
          a = 32'h8000_0000;
          b = 32'hFFFF_FFFF;
        end
      end
      lat = ($urandom_range(0, 15) == 0) ? 1000 : $urandom_range(1, 12);
      fl  = ($urandom_range(0, 7) == 0) ? $urandom_range(1, (lat > MAXC) ? MAXC : lat) : 0;
      do_op(op, sm, a, b, lat, fl);
    end

    rnd_rdy = 1'b0;
    repeat (5) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation still running, required finish");
    $fatal(1, "global timeout");
  end

endmodule
